// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SD SPI-mode card responder.
package sd_spi_pkg;

  // Command indices understood by the responder.
  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  // Bytes placed on MISO.
  localparam logic [7:0] FILL_BYTE       = 8'hFF;
  localparam logic [7:0] TOKEN_START     = 8'hFE;
  localparam logic [7:0] R1_READY        = 8'h00;
  localparam logic [7:0] R1_IDLE         = 8'h01;
  localparam logic [7:0] R1_ILLEGAL      = 8'h04;
  localparam logic [7:0] R1_IDLE_ILLEGAL = 8'h05;

  // OCR returned by CMD58: powered up, CCS=1 (block addressed).
  localparam logic [31:0] OCR_VALUE = 32'hC0FF8000;

  // Each state names the source of the next byte to be loaded into MISO.
  typedef enum logic [2:0] {
    S_RX_CMD,
    S_NCR,
    S_RESP,
    S_RD_WAIT,
    S_TOKEN,
    S_DATA,
    S_CRC
  } state_t;

endpackage

// File: rtl/sd_spi_slave_shifter.sv
// SPI mode-0 slave byte shifter: synchronizers, SCK edge detect, bit counter,
// RX/TX shift registers. Reports whole received bytes and byte-boundary loads.
module sd_spi_slave_shifter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic [7:0] tx_byte,
  output logic       spi_miso,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       load_next,
  output logic       first_rise
);

  logic       sck_meta_q, sck_sync_q, sck_prev_q;
  logic       mosi_meta_q, mosi_sync_q;
  logic       cs_meta_q, cs_sync_q, cs_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic       byte_done_q, byte_done_d;
  logic       load_pend_q, load_pend_d;
  logic       sck_rise, sck_fall, cs_assert;

  // Edge strobes; shifting is frozen while CS_n is high.
  assign sck_rise   = sck_sync_q & ~sck_prev_q & ~cs_sync_q;
  assign sck_fall   = ~sck_sync_q & sck_prev_q & ~cs_sync_q;
  assign cs_assert  = cs_prev_q & ~cs_sync_q;
  assign first_rise = sck_rise && (bit_cnt_q == 3'd0);

  // Bit counting, RX capture and TX shift/load at the byte boundary.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    byte_done_d = 1'b0;
    load_pend_d = load_pend_q;
    load_next   = 1'b0;
    if (cs_assert) begin
      bit_cnt_d = 3'd0;
      load_next = load_pend_q;
    end else if (sck_rise) begin
      rx_sr_d   = {rx_sr_q[6:0], mosi_sync_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_done_d = 1'b1;
        load_pend_d = 1'b1;
      end
    end else if (sck_fall) begin
      if (load_pend_q) load_next = 1'b1;
      else             tx_sr_d   = {tx_sr_q[6:0], 1'b1};
    end
    if (load_next) begin
      tx_sr_d     = tx_byte;
      load_pend_d = 1'b0;
    end
  end

  // Synchronizers and shifter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b1;
      mosi_sync_q <= 1'b1;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'hFF;
      byte_done_q <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the synchronizer a real 2-flop chain.
      sck_meta_q  <= spi_clk;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
      cs_meta_q   <= spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      byte_done_q <= byte_done_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign byte_done = byte_done_q;
  assign rx_byte   = rx_sr_q;
  // Raw CS_n also gates MISO so the line idles high without synchronizer lag.
  assign spi_miso  = (spi_cs_n | cs_sync_q) ? 1'b1 : tx_sr_q[7];

endmodule

// File: rtl/sd_spi_responder.sv
// SD card responder (SPI mode): decodes command frames, returns R1/R3/R7
// responses and streams CMD17 blocks from a byte-wide synchronous memory.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int ACMD41_BUSY_COUNT = 2,
  parameter int NCR_BYTES         = 1,
  parameter int READ_LATENCY      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        idle_state,
  output logic        mem_rd_en,
  output logic [31:0] mem_block,
  output logic [8:0]  mem_offset,
  input  logic [7:0]  mem_rd_data
);

  localparam logic [7:0] NCR_LAST  = 8'(NCR_BYTES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(READ_LATENCY - 1);
  localparam logic [7:0] BUSY_N    = 8'(ACMD41_BUSY_COUNT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  frame_cnt_q, frame_cnt_d;
  logic [37:0] cmd_buf_q, cmd_buf_d;      // {index, argument}
  logic        cur_rx_q, cur_rx_d;        // byte on the wire was loaded in S_RX_CMD
  logic [39:0] resp_q, resp_d;            // response bytes, first byte in [39:32]
  logic [2:0]  resp_last_q, resp_last_d;
  logic        rd_go_q, rd_go_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        idle_q, idle_d;
  logic        app_cmd_q, app_cmd_d;
  logic [7:0]  acmd_cnt_q, acmd_cnt_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic [31:0] mem_block_q, mem_block_d;
  logic [8:0]  mem_offset_q, mem_offset_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  rd_buf_q, rd_buf_d;
  logic [7:0]  tx_byte, rx_byte, acmd_inc, r1_now;
  logic        byte_done, load_next, first_rise;

  sd_spi_slave_shifter u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .tx_byte    (tx_byte),
    .spi_miso   (spi_miso),
    .rx_byte    (rx_byte),
    .byte_done  (byte_done),
    .load_next  (load_next),
    .first_rise (first_rise)
  );

  // Byte offered to the shifter at the next byte boundary.
  always_comb begin
    case (state_q)
      S_RESP:  tx_byte = resp_q[39:32];
      S_TOKEN: tx_byte = TOKEN_START;
      S_DATA:  tx_byte = rd_buf_q;
      default: tx_byte = FILL_BYTE;
    endcase
  end

  // Command capture/decode and per-byte sequencing of the reply stream.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_cnt_d  = frame_cnt_q;
    cmd_buf_d    = cmd_buf_q;
    cur_rx_d     = cur_rx_q;
    resp_d       = resp_q;
    resp_last_d  = resp_last_q;
    rd_go_d      = rd_go_q;
    cmd_valid_d  = 1'b0;
    cmd_index_d  = cmd_index_q;
    cmd_arg_d    = cmd_arg_q;
    idle_d       = idle_q;
    app_cmd_d    = app_cmd_q;
    acmd_cnt_d   = acmd_cnt_q;
    mem_block_d  = mem_block_q;
    mem_offset_d = mem_offset_q;
    mem_rd_en_d  = first_rise && (state_q == S_DATA);
    rd_pend_d    = mem_rd_en_q;
    rd_buf_d     = rd_pend_q ? mem_rd_data : rd_buf_q;
    acmd_inc     = (acmd_cnt_q == 8'hFF) ? 8'hFF : acmd_cnt_q + 8'd1;
    r1_now       = {7'b0, idle_q};

    if (byte_done && cur_rx_q && (state_q == S_RX_CMD)) begin
      if (frame_cnt_q == 3'd0) begin
        if (rx_byte[7:6] == 2'b01) begin
          cmd_buf_d   = {rx_byte[5:0], 32'h0};
          frame_cnt_d = 3'd1;
        end
      end else if (frame_cnt_q != 3'd5) begin
        cmd_buf_d   = {cmd_buf_q[37:32], cmd_buf_q[23:0], rx_byte};
        frame_cnt_d = frame_cnt_q + 3'd1;
      end else begin
        // CRC byte received: the frame is complete.
        frame_cnt_d = 3'd0;
        cmd_valid_d = 1'b1;
        cmd_index_d = cmd_buf_q[37:32];
        cmd_arg_d   = cmd_buf_q[31:0];
        state_d     = S_NCR;
        cnt_d       = 8'd0;
        app_cmd_d   = 1'b0;
        rd_go_d     = 1'b0;
        resp_last_d = 3'd0;
        resp_d      = {R1_ILLEGAL | r1_now, 32'hFFFF_FFFF};
        case (cmd_buf_q[37:32])
          CMD0: begin
            idle_d     = 1'b1;
            acmd_cnt_d = 8'd0;
            resp_d     = {R1_IDLE, 32'hFFFF_FFFF};
          end
          CMD8: begin
            resp_d      = {R1_IDLE, 24'h000001, cmd_buf_q[7:0]};
            resp_last_d = 3'd4;
          end
          CMD55: begin
            app_cmd_d = 1'b1;
            resp_d    = {r1_now, 32'hFFFF_FFFF};
          end
          CMD41: begin
            if (app_cmd_q) begin
              acmd_cnt_d = acmd_inc;
              if (acmd_inc > BUSY_N) begin
                idle_d = 1'b0;
                resp_d = {R1_READY, 32'hFFFF_FFFF};
              end else begin
                resp_d = {R1_IDLE, 32'hFFFF_FFFF};
              end
            end
          end
          CMD58: begin
            resp_d      = {r1_now, OCR_VALUE};
            resp_last_d = 3'd4;
          end
          CMD17: begin
            if (idle_q) begin
              resp_d = {R1_IDLE_ILLEGAL, 32'hFFFF_FFFF};
            end else begin
              resp_d      = {R1_READY, 32'hFFFF_FFFF};
              mem_block_d = cmd_buf_q[31:0];
              rd_go_d     = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (load_next) begin
      cur_rx_d = (state_q == S_RX_CMD);
      case (state_q)
        S_NCR: begin
          if (cnt_q == NCR_LAST) begin
            state_d = S_RESP;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_RESP: begin
          resp_d = {resp_q[31:0], FILL_BYTE};
          if (cnt_q == {5'b0, resp_last_q}) begin
            state_d = rd_go_q ? S_RD_WAIT : S_RX_CMD;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_RD_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_d = S_TOKEN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_TOKEN: begin
          state_d      = S_DATA;
          mem_offset_d = 9'd0;
        end
        S_DATA: begin
          if (mem_offset_q == 9'd511) begin
            state_d      = S_CRC;
            mem_offset_d = 9'd0;
            cnt_d        = 8'd0;
          end else begin
            mem_offset_d = mem_offset_q + 9'd1;
          end
        end
        S_CRC: begin
          if (cnt_q == 8'd1) begin
            state_d = S_RX_CMD;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Transaction state register; only reset_n clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RX_CMD;
      cnt_q        <= 8'd0;
      frame_cnt_q  <= 3'd0;
      cmd_buf_q    <= '0;
      cur_rx_q     <= 1'b1;
      resp_q       <= '1;
      resp_last_q  <= 3'd0;
      rd_go_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_index_q  <= 6'd0;
      cmd_arg_q    <= 32'd0;
      idle_q       <= 1'b1;
      app_cmd_q    <= 1'b0;
      acmd_cnt_q   <= 8'd0;
      mem_rd_en_q  <= 1'b0;
      mem_block_q  <= 32'd0;
      mem_offset_q <= 9'd0;
      rd_pend_q    <= 1'b0;
      rd_buf_q     <= 8'hFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      cmd_buf_q    <= cmd_buf_d;
      cur_rx_q     <= cur_rx_d;
      resp_q       <= resp_d;
      resp_last_q  <= resp_last_d;
      rd_go_q      <= rd_go_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_index_q  <= cmd_index_d;
      cmd_arg_q    <= cmd_arg_d;
      idle_q       <= idle_d;
      app_cmd_q    <= app_cmd_d;
      acmd_cnt_q   <= acmd_cnt_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_block_q  <= mem_block_d;
      mem_offset_q <= mem_offset_d;
      rd_pend_q    <= rd_pend_d;
      rd_buf_q     <= rd_buf_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_index  = cmd_index_q;
  assign cmd_arg    = cmd_arg_q;
  assign idle_state = idle_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_block  = mem_block_q;
  assign mem_offset = mem_offset_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench for sd_spi_responder: a mode-0 SPI host model, a
// table of command/response vectors, and hand-written CMD17/reset/CS cases.
module tb_sd_spi_responder;
  import sd_spi_pkg::*;

  localparam int HALF = 40;  // SCK half period = 4 clk

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        idle_state;
  logic        mem_rd_en;
  logic [31:0] mem_block;
  logic [8:0]  mem_offset;
  logic [7:0]  mem_rd_data = 8'h00;

  sd_spi_responder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .cmd_valid   (cmd_valid),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .idle_state  (idle_state),
    .mem_rd_en   (mem_rd_en),
    .mem_block   (mem_block),
    .mem_offset  (mem_offset),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          nresp;
    logic [39:0] resp;   // first response byte in [39:32]
    int          tail;   // extra 0xFF bytes expected afterwards
    logic        idle;
  } vec_t;

  vec_t       vecs[16];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         valid_cnt = 0;
  int         rd_cnt = 0;
  int         off_err = 0;
  logic [8:0] exp_off = 9'd0;
  logic [7:0] exp_q[$];
  bit         cs_toggle = 1'b0;

  // Synchronous memory model: byte at offset N is N[7:0].
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_offset[7:0];

  // Event monitors sampled on the inactive edge.
  always @(negedge clk) begin
    if (cmd_valid) valid_cnt <= valid_cnt + 1;
    if (mem_rd_en) begin
      if (mem_offset != exp_off) off_err <= off_err + 1;
      exp_off <= exp_off + 9'd1;
      rd_cnt  <= rd_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One host byte; the expected MISO byte goes through the scoreboard queue.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] rx;
    logic [7:0] want;
    exp_q.push_back(exp);
    if (cs_toggle) begin spi_cs_n = 1'b0; #HALF; end
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #HALF;
      spi_clk = 1'b1;
      rx[i] = spi_miso;
      #HALF;
      spi_clk = 1'b0;
    end
    if (cs_toggle) begin #HALF; spi_cs_n = 1'b1; #HALF; end
    want = exp_q.pop_front();
    check("miso_byte", {56'b0, rx}, {56'b0, want});
  endtask

  task automatic run_cmd(input vec_t v);
    int v0;
    v0 = valid_cnt;
    xfer({2'b01, v.idx}, FILL_BYTE);
    for (int b = 3; b >= 0; b--) xfer(v.arg[8*b +: 8], FILL_BYTE);
    xfer(8'h95, FILL_BYTE);
    xfer(FILL_BYTE, FILL_BYTE);  // NCR fill
    for (int k = 0; k < v.nresp; k++) xfer(FILL_BYTE, v.resp[39-8*k -: 8]);
    for (int k = 0; k < v.tail; k++) xfer(FILL_BYTE, FILL_BYTE);
    check("cmd_valid_pulses", 64'(valid_cnt), 64'(v0 + 1));
    check("cmd_index", {58'b0, cmd_index}, {58'b0, v.idx});
    check("cmd_arg", {32'b0, cmd_arg}, {32'b0, v.arg});
    check("idle_state", {63'b0, idle_state}, {63'b0, v.idle});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v17;
    int   r0;
    vecs[0]  = '{CMD0,  32'h0,        1, {8'h01, 32'h0},         0, 1'b1};
    vecs[1]  = '{CMD17, 32'h5,        1, {8'h05, 32'h0},         3, 1'b1};
    vecs[2]  = '{CMD41, 32'h40000000, 1, {8'h05, 32'h0},         0, 1'b1};
    vecs[3]  = '{6'd13, 32'h0,        1, {8'h05, 32'h0},         0, 1'b1};
    vecs[4]  = '{CMD8,  32'h000001AA, 5, 40'h01_00_00_01_AA,     0, 1'b1};
    vecs[5]  = '{CMD55, 32'h0,        1, {8'h01, 32'h0},         0, 1'b1};
    vecs[6]  = '{CMD41, 32'h40000000, 1, {8'h01, 32'h0},         0, 1'b1};
    vecs[7]  = '{CMD55, 32'h0,        1, {8'h01, 32'h0},         0, 1'b1};
    vecs[8]  = '{CMD41, 32'h40000000, 1, {8'h01, 32'h0},         0, 1'b1};
    vecs[9]  = '{CMD55, 32'h0,        1, {8'h01, 32'h0},         0, 1'b1};
    vecs[10] = '{CMD41, 32'h40000000, 1, {8'h00, 32'h0},         0, 1'b0};
    vecs[11] = '{CMD58, 32'h0,        5, 40'h00_C0_FF_80_00,     0, 1'b0};
    vecs[12] = '{6'd13, 32'h0,        1, {8'h04, 32'h0},         0, 1'b0};
    vecs[13] = '{CMD55, 32'h0,        1, {8'h00, 32'h0},         0, 1'b0};
    vecs[14] = '{6'd13, 32'h0,        1, {8'h04, 32'h0},         0, 1'b0};
    vecs[15] = '{CMD41, 32'h40000000, 1, {8'h04, 32'h0},         0, 1'b0};

    // Reset state.
    #100;
    check("rst_miso", {63'b0, spi_miso}, 64'd1);
    check("rst_cmd_valid", {63'b0, cmd_valid}, 64'd0);
    check("rst_idle", {63'b0, idle_state}, 64'd1);
    check("rst_mem_rd_en", {63'b0, mem_rd_en}, 64'd0);
    reset_n = 1'b1;
    #HALF;
    spi_cs_n = 1'b0;
    #HALF;

    // Idle traffic and non-start bytes are discarded.
    for (int i = 0; i < 4; i++) xfer(8'hFF, FILL_BYTE);
    xfer(8'h3F, FILL_BYTE);
    xfer(8'h80, FILL_BYTE);
    check("no_cmd_valid", 64'(valid_cnt), 64'd0);
    check("idle_after_ff", {63'b0, idle_state}, 64'd1);

    // Command/response table.
    for (int i = 0; i < 16; i++) run_cmd(vecs[i]);
    check("no_reads_yet", 64'(rd_cnt), 64'd0);

    // Full CMD17 block read.
    r0 = rd_cnt;
    v17 = '{CMD17, 32'h10, 1, {8'h00, 32'h0}, 0, 1'b0};
    run_cmd(v17);
    for (int i = 0; i < 4; i++) xfer(FILL_BYTE, FILL_BYTE);
    xfer(FILL_BYTE, TOKEN_START);
    for (int i = 0; i < 512; i++) xfer(FILL_BYTE, 8'(i));
    xfer(FILL_BYTE, FILL_BYTE);
    xfer(FILL_BYTE, FILL_BYTE);
    xfer(FILL_BYTE, FILL_BYTE);
    xfer(FILL_BYTE, FILL_BYTE);
    check("mem_block", {32'b0, mem_block}, 64'h10);
    check("rd_pulses", 64'(rd_cnt - r0), 64'd512);
    check("rd_offsets", 64'(off_err), 64'd0);
    check("offset_after", {55'b0, mem_offset}, 64'd0);

    // Reset asserted in the middle of data byte 100 (0x64).
    v17 = '{CMD17, 32'h20, 1, {8'h00, 32'h0}, 0, 1'b0};
    run_cmd(v17);
    for (int i = 0; i < 4; i++) xfer(FILL_BYTE, FILL_BYTE);
    xfer(FILL_BYTE, TOKEN_START);
    for (int i = 0; i < 100; i++) xfer(FILL_BYTE, 8'(i));
    for (int i = 0; i < 4; i++) begin
      #HALF; spi_clk = 1'b1; #HALF; spi_clk = 1'b0;
    end
    #30;
    check("miso_mid_byte", {63'b0, spi_miso}, 64'd0);
    reset_n = 1'b0;
    #1;
    check("rstmid_miso", {63'b0, spi_miso}, 64'd1);
    check("rstmid_state", 64'(dut.state_q), 64'(S_RX_CMD));
    check("rstmid_idle", {63'b0, idle_state}, 64'd1);
    check("rstmid_block", {32'b0, mem_block}, 64'd0);
    check("rstmid_offset", {55'b0, mem_offset}, 64'd0);
    check("rstmid_index", {58'b0, cmd_index}, 64'd0);
    #HALF;
    spi_cs_n = 1'b1;
    reset_n = 1'b1;
    #HALF;

    // CMD0 exchange with CS toggled around every byte.
    cs_toggle = 1'b1;
    run_cmd(vecs[0]);
    cs_toggle = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
